// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: loader FSM states and the
// instruction-memory geometry that must agree with instruction_memory.
package imem_loader_pkg;

    localparam int IMEM_DEPTH  = 256;
    localparam int IMEM_ADDR_W = $clog2(IMEM_DEPTH);

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERR
    } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream ingress plus instruction-memory write port of the loader.
// slave = the loader, master = byte source / memory side environment.
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
) ();

    logic              Rx_Valid;
    logic [7:0]        Rx_Data;
    logic              Rx_Ready;
    logic              Mem_We;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [31:0]       Mem_WData;

    modport slave (
        input  Rx_Valid,
        input  Rx_Data,
        output Rx_Ready,
        output Mem_We,
        output Mem_Addr,
        output Mem_WData
    );

    modport master (
        output Rx_Valid,
        output Rx_Data,
        input  Rx_Ready,
        input  Mem_We,
        input  Mem_Addr,
        input  Mem_WData
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs four little-endian bytes into a 32-bit word; word_vld_o is combinational on the
// 4th byte, so it has zero latency. No backpressure of its own: it takes every byte_vld_i.
module imem_loader_byte_packer (
    input  logic        CLK,
    input  logic        RST,
    input  logic        clr_i,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_dat_i,
    output logic        word_vld_o,
    output logic [31:0] word_dat_o
);

    logic [1:0]  idx_q,   idx_d;
    logic [23:0] shift_q, shift_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            idx_q   <= 2'd0;
            shift_q <= 24'd0;
        end else begin
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // Bytes enter at the top and shift down, so after three bytes shift_q = {b2,b1,b0}.
    always_comb begin
        idx_d      = idx_q;
        shift_d    = shift_q;
        word_vld_o = 1'b0;
        word_dat_o = {byte_dat_i, shift_q};
        if (clr_i) begin
            idx_d   = 2'd0;
            shift_d = 24'd0;
        end else if (byte_vld_i) begin
            shift_d = {byte_dat_i, shift_q[23:8]};
            idx_d   = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
                word_vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte image into instruction memory; Mem_We
// pulses 1 cycle after each word's 4th byte. Rx_Ready depends on state only (low in DONE/ERR).
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          Start,
    imem_loader_if.slave  bus,
    output logic          Core_Hold,
    output logic          Load_Done,
    output logic          Load_Err
);

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    loader_state_t     state_q, state_d;
    logic [15:0]       n_q, n_d;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic [7:0]        xor_q, xor_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic              rx_rdy;
    logic              rx_xfer;
    logic [15:0]       n_new;
    logic              pk_clr;
    logic              pk_word_vld;
    logic [31:0]       pk_word;

    assign rx_rdy  = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                     (state_q == S_DATA)   || (state_q == S_CHECK);
    assign rx_xfer = bus.Rx_Valid && rx_rdy;
    assign n_new   = {bus.Rx_Data, n_q[7:0]};

    imem_loader_byte_packer u_packer (
        .CLK        (CLK),
        .RST        (RST),
        .clr_i      (pk_clr),
        .byte_vld_i (rx_xfer && (state_q == S_DATA)),
        .byte_dat_i (bus.Rx_Data),
        .word_vld_o (pk_word_vld),
        .word_dat_o (pk_word)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_LEN_LO;
            n_q         <= 16'd0;
            word_cnt_q  <= 16'd0;
            xor_q       <= 8'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            word_cnt_q  <= word_cnt_d;
            xor_q       <= xor_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        word_cnt_d  = word_cnt_q;
        xor_d       = xor_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        pk_clr      = 1'b0;
        case (state_q)
            S_LEN_LO: begin
                if (rx_xfer) begin
                    n_d[7:0] = bus.Rx_Data;
                    xor_d    = xor_q ^ bus.Rx_Data;
                    state_d  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (rx_xfer) begin
                    n_d   = n_new;
                    xor_d = xor_q ^ bus.Rx_Data;
                    if ({1'b0, n_new} > DEPTH_W) begin
                        state_d = S_ERR;
                    end else if (n_new == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_xfer) begin
                    xor_d = xor_q ^ bus.Rx_Data;
                end
                // word_cnt_q never exceeds DEPTH-1 here, so the address cannot wrap.
                if (pk_word_vld) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = word_cnt_q[ADDR_W-1:0];
                    mem_wdata_d = pk_word;
                    word_cnt_d  = word_cnt_q + 16'd1;
                    if (word_cnt_q == n_q - 16'd1) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (rx_xfer) begin
                    state_d = (bus.Rx_Data == xor_q) ? S_DONE : S_ERR;
                end
            end
            S_DONE, S_ERR: begin
                if (Start) begin
                    state_d    = S_LEN_LO;
                    n_d        = 16'd0;
                    word_cnt_d = 16'd0;
                    xor_d      = 8'd0;
                    pk_clr     = 1'b1;
                end
            end
            default: begin
                state_d = S_LEN_LO;
            end
        endcase
    end

    assign bus.Rx_Ready  = rx_rdy;
    assign bus.Mem_We    = mem_we_q;
    assign bus.Mem_Addr  = mem_addr_q;
    assign bus.Mem_WData = mem_wdata_q;

    assign Load_Done = (state_q == S_DONE);
    assign Load_Err  = (state_q == S_ERR);
    assign Core_Hold = (state_q != S_DONE);

endmodule
